// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: register file read, immediate extension, destination selection, hazard history.
// Optional macro REGFILE_BYPASS_EN: same-cycle writeback data is forwarded into the register reads.
module id_ex_stage #(
  parameter int unsigned NREG     = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned JAL_LINK = 31
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [5:0]    opcode,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [5:0]    func,
  input  logic [4:0]    shamt,
  input  logic [15:0]   immediate,
  input  logic [25:0]   address,
  input  logic [7:0]    controller,
  input  logic          flush,
  input  logic          wb_we,
  input  logic [4:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [5:0]    ex_opcode,
  output logic [5:0]    ex_func,
  output logic [4:0]    ex_shamt,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [31:0]   ex_imm,
  output logic [25:0]   ex_jaddr,
  output logic [4:0]    ex_dest,
  output logic          ex_mem_read,
  output logic          ex_valid,
  output logic [4:0]    rd_fut_1,
  output logic [4:0]    rd_fut_2,
  output logic [4:0]    rd_fut_3,
  output logic [5:0]    op_fut_1,
  output logic [5:0]    op_fut_2
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] FnJr    = 6'b001000;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  logic [5:0]    opcode_d, opcode_q, func_d, func_q, op_fut_2_d, op_fut_2_q;
  logic [4:0]    shamt_d, shamt_q, dest_d, dest_q;
  logic [4:0]    rd_fut_2_d, rd_fut_2_q, rd_fut_3_d, rd_fut_3_q;
  logic [DW-1:0] rs_data_d, rs_data_q, rt_data_d, rt_data_q;
  logic [31:0]   imm_d, imm_q;
  logic [25:0]   jaddr_d, jaddr_q;
  logic          mem_read_d, mem_read_q, valid_d, valid_q;

  logic          wb_hit;
  logic          slot_valid;
  logic [4:0]    dest_raw;
  logic [DW-1:0] rs_rd, rt_rd;

  assign wb_hit     = wb_we && (wb_addr != 5'd0);
  assign slot_valid = (controller[1:0] == 2'b11) && !flush;

  always_comb begin
    regs_d = regs_q;
    if (wb_hit) regs_d[wb_addr] = wb_data;
  end

  always_comb begin
    rs_rd = (rs == 5'd0) ? '0 : regs_q[rs];
    rt_rd = (rt == 5'd0) ? '0 : regs_q[rt];
`ifdef REGFILE_BYPASS_EN
    if (wb_hit && (wb_addr == rs)) rs_rd = wb_data;
    if (wb_hit && (wb_addr == rt)) rt_rd = wb_data;
`endif
  end

  always_comb begin
    dest_raw = 5'd0;
    if (opcode == OpRtype) begin
      dest_raw = (func == FnJr) ? 5'd0 : rd;
    end else if (opcode == OpJal) begin
      dest_raw = 5'(JAL_LINK);
    end else if ((opcode == OpLw) || (opcode[5:3] == 3'b001)) begin
      dest_raw = rd;
    end
  end

  always_comb begin
    opcode_d   = '0;
    func_d     = '0;
    shamt_d    = '0;
    rs_data_d  = '0;
    rt_data_d  = '0;
    imm_d      = '0;
    jaddr_d    = '0;
    dest_d     = '0;
    mem_read_d = 1'b0;
    valid_d    = 1'b0;
    if (slot_valid) begin
      opcode_d   = opcode;
      func_d     = func;
      shamt_d    = shamt;
      rs_data_d  = rs_rd;
      rt_data_d  = rt_rd;
      imm_d      = {{16{immediate[15]}}, immediate};
      jaddr_d    = address;
      dest_d     = dest_raw;
      mem_read_d = controller[7];
      valid_d    = 1'b1;
    end
    // History shifts every cycle so bubbles age older destinations out.
    rd_fut_2_d = dest_q;
    rd_fut_3_d = rd_fut_2_q;
    op_fut_2_d = opcode_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      opcode_q   <= '0;
      func_q     <= '0;
      shamt_q    <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      jaddr_q    <= '0;
      dest_q     <= '0;
      mem_read_q <= 1'b0;
      valid_q    <= 1'b0;
      rd_fut_2_q <= '0;
      rd_fut_3_q <= '0;
      op_fut_2_q <= '0;
    end else begin
      regs_q     <= regs_d;
      opcode_q   <= opcode_d;
      func_q     <= func_d;
      shamt_q    <= shamt_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      jaddr_q    <= jaddr_d;
      dest_q     <= dest_d;
      mem_read_q <= mem_read_d;
      valid_q    <= valid_d;
      rd_fut_2_q <= rd_fut_2_d;
      rd_fut_3_q <= rd_fut_3_d;
      op_fut_2_q <= op_fut_2_d;
    end
  end

  assign ex_opcode   = opcode_q;
  assign ex_func     = func_q;
  assign ex_shamt    = shamt_q;
  assign ex_rs_data  = rs_data_q;
  assign ex_rt_data  = rt_data_q;
  assign ex_imm      = imm_q;
  assign ex_jaddr    = jaddr_q;
  assign ex_dest     = dest_q;
  assign ex_mem_read = mem_read_q;
  assign ex_valid    = valid_q;
  assign rd_fut_1    = dest_q;
  assign rd_fut_2    = rd_fut_2_q;
  assign rd_fut_3    = rd_fut_3_q;
  assign op_fut_1    = opcode_q;
  assign op_fut_2    = op_fut_2_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expected values are hand-computed constants.
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd, shamt, wb_addr;
  logic [15:0] immediate;
  logic [25:0] address;
  logic [7:0]  controller;
  logic        flush, wb_we;
  logic [31:0] wb_data;

  logic [5:0]  ex_opcode, ex_func, op_fut_1, op_fut_2;
  logic [4:0]  ex_shamt, ex_dest, rd_fut_1, rd_fut_2, rd_fut_3;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [25:0] ex_jaddr;
  logic        ex_mem_read, ex_valid;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage dut (
    .clock(clock), .reset(reset), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .func(func), .shamt(shamt), .immediate(immediate), .address(address),
    .controller(controller), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_opcode(ex_opcode), .ex_func(ex_func), .ex_shamt(ex_shamt),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_jaddr(ex_jaddr), .ex_dest(ex_dest), .ex_mem_read(ex_mem_read),
    .ex_valid(ex_valid), .rd_fut_1(rd_fut_1), .rd_fut_2(rd_fut_2),
    .rd_fut_3(rd_fut_3), .op_fut_1(op_fut_1), .op_fut_2(op_fut_2)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge and outputs are sampled there too.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    opcode = '0; rs = '0; rt = '0; rd = '0; func = '0; shamt = '0;
    immediate = '0; address = '0; controller = '0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    idle();
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_we = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_eq("rst_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("rst_dest", {27'd0, ex_dest}, 32'd0);
    check_eq("rst_op_fut_1", {26'd0, op_fut_1}, 32'd0);

    // Writeback then add r4 = r3 + r0
    wb_write(5'd3, 32'h0000_00AA);
    wb_write(5'd5, 32'h0000_0077);
    idle();
    opcode = 6'b000000; rs = 5'd3; rt = 5'd0; rd = 5'd4; func = 6'b100000; controller = 8'h03;
    step();
    check_eq("add_rs_data", ex_rs_data, 32'h0000_00AA);
    check_eq("add_rt_data", ex_rt_data, 32'd0);
    check_eq("add_dest", {27'd0, ex_dest}, 32'd4);
    check_eq("add_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("add_func", {26'd0, ex_func}, 32'h20);

    // Two bubbles flush history, then addi rd=7 and two more bubbles
    idle(); step(); step();
    opcode = 6'b001000; rd = 5'd7; immediate = 16'h0010; controller = 8'h03;
    step();
    check_eq("h0_f1", {27'd0, rd_fut_1}, 32'd7);
    check_eq("h0_f2", {27'd0, rd_fut_2}, 32'd0);
    check_eq("h0_f3", {27'd0, rd_fut_3}, 32'd0);
    check_eq("addi_imm", ex_imm, 32'h0000_0010);
    idle(); step();
    check_eq("h1_f1", {27'd0, rd_fut_1}, 32'd0);
    check_eq("h1_f2", {27'd0, rd_fut_2}, 32'd7);
    check_eq("h1_f3", {27'd0, rd_fut_3}, 32'd0);
    check_eq("bubble_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("bubble_imm", ex_imm, 32'd0);
    step();
    check_eq("h2_f1", {27'd0, rd_fut_1}, 32'd0);
    check_eq("h2_f2", {27'd0, rd_fut_2}, 32'd0);
    check_eq("h2_f3", {27'd0, rd_fut_3}, 32'd7);

    // lw with negative offset
    idle();
    opcode = 6'b100011; rd = 5'd9; immediate = 16'hFFFC; controller = 8'h83;
    step();
    check_eq("lw_imm", ex_imm, 32'hFFFF_FFFC);
    check_eq("lw_mem_read", {31'd0, ex_mem_read}, 32'd1);
    check_eq("lw_dest", {27'd0, ex_dest}, 32'd9);

    // jal, then the same instruction flushed
    idle();
    opcode = 6'b000011; address = 26'h0000100; controller = 8'h03;
    step();
    check_eq("jal_dest", {27'd0, ex_dest}, 32'd31);
    check_eq("jal_op_fut_1", {26'd0, op_fut_1}, 32'h03);
    check_eq("jal_op_fut_2", {26'd0, op_fut_2}, 32'h23);
    check_eq("jal_jaddr", {6'd0, ex_jaddr}, 32'h100);
    check_eq("jal_mem_read", {31'd0, ex_mem_read}, 32'd0);
    flush = 1'b1;
    step();
    check_eq("flush_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("flush_f1", {27'd0, rd_fut_1}, 32'd0);
    check_eq("flush_f2", {27'd0, rd_fut_2}, 32'd31);
    check_eq("flush_jaddr", {6'd0, ex_jaddr}, 32'd0);
    check_eq("flush_op_fut_2", {26'd0, op_fut_2}, 32'h03);

    // Destination decode corner cases
    idle();
    opcode = 6'b000000; func = 6'b001000; rd = 5'd12; rs = 5'd3; controller = 8'h03;
    step();
    check_eq("jr_dest", {27'd0, ex_dest}, 32'd0);
    check_eq("jr_valid", {31'd0, ex_valid}, 32'd1);
    opcode = 6'b101011; func = '0; rd = 5'd5;
    step();
    check_eq("sw_dest", {27'd0, ex_dest}, 32'd0);
    opcode = 6'b000100;
    step();
    check_eq("beq_dest", {27'd0, ex_dest}, 32'd0);
    opcode = 6'b111111;
    step();
    check_eq("other_dest", {27'd0, ex_dest}, 32'd0);
    opcode = 6'b001101; shamt = 5'd9;
    step();
    check_eq("ori_dest", {27'd0, ex_dest}, 32'd5);
    check_eq("ori_shamt", {27'd0, ex_shamt}, 32'd9);
    controller = 8'h81;
    step();
    check_eq("half_ctrl_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("half_ctrl_mem_read", {31'd0, ex_mem_read}, 32'd0);

    // Same-cycle writeback and read of r6
    wb_write(5'd6, 32'h0000_0055);
    idle();
    opcode = 6'b000000; func = 6'b100000; rs = 5'd6; rt = 5'd6; rd = 5'd1; controller = 8'h03;
    wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h0000_1234;
    step();
`ifdef REGFILE_BYPASS_EN
    check_eq("wb_same_rs", ex_rs_data, 32'h0000_1234);
    check_eq("wb_same_rt", ex_rt_data, 32'h0000_1234);
`else
    check_eq("wb_same_rs", ex_rs_data, 32'h0000_0055);
    check_eq("wb_same_rt", ex_rt_data, 32'h0000_0055);
`endif
    wb_we = 1'b0;
    step();
    check_eq("wb_next_rs", ex_rs_data, 32'h0000_1234);

    // r0 writes are ignored, also in the same cycle
    rs = 5'd0; rt = 5'd0;
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    step();
    check_eq("r0_same", ex_rs_data, 32'd0);
    wb_we = 1'b0;
    step();
    check_eq("r0_next", ex_rt_data, 32'd0);

    // Mid-cycle reset after traffic
    idle();
    opcode = 6'b100011; rs = 5'd5; rd = 5'd9; immediate = 16'h8000; controller = 8'h83;
    step();
    check_eq("pre_rst_rs", ex_rs_data, 32'h0000_0077);
    step();
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("mid_rst_imm", ex_imm, 32'd0);
    check_eq("mid_rst_mem_read", {31'd0, ex_mem_read}, 32'd0);
    check_eq("mid_rst_f1", {27'd0, rd_fut_1}, 32'd0);
    check_eq("mid_rst_f2", {27'd0, rd_fut_2}, 32'd0);
    check_eq("mid_rst_op_fut_2", {26'd0, op_fut_2}, 32'd0);
    reset = 1'b0;
    idle();
    opcode = 6'b000000; func = 6'b100000; rs = 5'd5; rt = 5'd3; rd = 5'd2; controller = 8'h03;
    step();
    check_eq("post_rst_r5", ex_rs_data, 32'd0);
    check_eq("post_rst_r3", ex_rt_data, 32'd0);
    check_eq("post_rst_valid", {31'd0, ex_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
